// File: rtl/if_id_fifo_pkg.sv
// Shared IF/ID constants and the buffered entry layout.
// Also used by the IF, ID and hazard logic.
package if_id_fifo_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0,x0,0: shown to decode whenever the buffer holds nothing
  localparam logic [XLEN-1:0] NOP_INST_WORD = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_fifo.sv
// Two-entry (DEPTH) decoupling buffer between instruction fetch and decode.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   in_valid/in_inst/in_pc/in_pc4   fetch-side entry
//   in_ready                 buffer not full (registered state only)
//   pc_hold                  ~in_ready, freezes the PC register
//   flush                    redirect from execute, empties the buffer
//   out_valid/out_inst/out_pc/out_pc4   head entry; NOP/0/0 when empty
//   out_ready                decode consumes the head
module if_id_fifo
  import if_id_fifo_pkg::*;
#(
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] NOP_INST = NOP_INST_WORD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc4,
  output logic            in_ready,
  output logic            pc_hold,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc4,
  input  logic            out_ready
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] count;
  if_id_entry_t     mem [DEPTH];
  if_id_entry_t     head;
  logic             push;
  logic             pop;

  // Advance a pointer, wrapping modulo DEPTH (top bit stays clear).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return PTR_W'(AW'(p[AW-1:0] + AW'(1)));
  endfunction

  // Handshake: readiness comes from registered occupancy only.
  assign in_ready  = (count != FULL_CNT);
  assign pc_hold   = ~in_ready;
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem[rd_ptr[AW-1:0]];

  // Head presentation; constants when empty so stale storage never leaks.
  always_comb begin
    out_inst = NOP_INST;
    out_pc   = '0;
    out_pc4  = '0;
    if (out_valid) begin
      out_inst = head.inst;
      out_pc   = head.pc;
      out_pc4  = head.pc4;
    end
  end

  // Storage array; no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem[wr_ptr[AW-1:0]] <= '{inst: in_inst, pc: in_pc, pc4: in_pc4};
    end
  end

  // Pointers and occupancy: rst > flush > push/pop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count <= FULL_CNT);
      assert (!(pop && (count == '0)));
    end
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + PTR_W'(1);
        2'b01:   count <= count - PTR_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_fifo.sv
// Self-checking bench for if_id_fifo: directed plan followed by random
// traffic, compared against a queue-based reference model.
module tb_if_id_fifo;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [31:0] in_pc4;
  logic        in_ready;
  logic        pc_hold;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc4;
  logic        out_ready;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: ordered queue of {inst, pc, pc4}
  logic [95:0] q[$];

  if_id_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .in_pc4    (in_pc4),
    .in_ready  (in_ready),
    .pc_hold   (pc_hold),
    .flush     (flush),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_pc4   (out_pc4),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle, compare outputs with the model, then advance both.
  task automatic step(input logic r, input logic f, input logic iv,
                      input logic [31:0] inst, input logic [31:0] pc,
                      input logic [31:0] pc4, input logic ordy);
    logic [95:0] h;
    logic        m_push;
    logic        m_pop;
    rst = r; flush = f; in_valid = iv;
    in_inst = inst; in_pc = pc; in_pc4 = pc4; out_ready = ordy;
    #1;
    h = (q.size() != 0) ? q[0] : {NOP, 32'h0, 32'h0};
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
    chk("pc_hold",   32'(pc_hold),   32'(q.size() >= DEPTH));
    chk("out_inst",  out_inst, h[95:64]);
    chk("out_pc",    out_pc,   h[63:32]);
    chk("out_pc4",   out_pc4,  h[31:0]);
    m_push = iv && (q.size() < DEPTH);
    m_pop  = ordy && (q.size() != 0);
    @(posedge clk);
    if (r || f) begin
      q.delete();
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back({inst, pc, pc4});
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, ordy);
  endtask

  task automatic push_pc(input logic [31:0] pc, input logic ordy);
    step(1'b0, 1'b0, 1'b1, 32'h0010_0093 ^ pc, pc, pc + 32'd4, ordy);
  endtask

  initial begin
    logic        r;
    logic        f;
    logic        iv;
    logic        ordy;
    logic [31:0] pc;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0; in_pc4 = '0;
    @(posedge clk);
    #1;
    q.delete();

    // Reset state and idle
    chk("reset_nop_inst", out_inst, 32'h0000_0013);
    idle(1'b0); idle(1'b0); idle(1'b1);

    // Single pass-through
    step(1'b0, 1'b0, 1'b1, 32'h0050_0093, 32'h0, 32'h4, 1'b1);
    chk("pass_inst", out_inst, 32'h0050_0093);
    idle(1'b1);
    idle(1'b1);

    // Fill and stall; third push refused
    push_pc(32'h0, 1'b0);
    push_pc(32'h4, 1'b0);
    push_pc(32'h8, 1'b0);
    idle(1'b1); idle(1'b1); idle(1'b1);

    // Simultaneous push/pop at count=1
    push_pc(32'h0, 1'b1);
    push_pc(32'h4, 1'b1);
    push_pc(32'h8, 1'b1);
    push_pc(32'hC, 1'b1);
    idle(1'b1); idle(1'b1);

    // Flush with a full buffer plus a concurrent push
    push_pc(32'h10, 1'b0);
    push_pc(32'h14, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0018, 32'h18, 32'h1C, 1'b0);
    idle(1'b1); idle(1'b1);

    // Reset mid-operation with push and pop requested
    push_pc(32'h20, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_0024, 32'h24, 32'h28, 1'b1);
    idle(1'b1); idle(1'b1);

    // Random traffic
    pc = 32'h100;
    for (int i = 0; i < 400; i++) begin
      r    = ($urandom_range(63) == 0);
      f    = ($urandom_range(15) == 0);
      iv   = ($urandom_range(3) != 0);
      ordy = ($urandom_range(2) != 0);
      step(r, f, iv, $urandom, pc, pc + 32'd4, ordy);
      if (iv) pc = pc + 32'd4;
    end
    idle(1'b1); idle(1'b1); idle(1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
